dct_block_reader: RTL and testbench

- Reads a finished 512x512, 8-bit image from the 32768x64 result SRAM and streams it out one 8x8 block at a time over a valid/ready interface.
- Each 64-bit SRAM word holds one row of 8 pixels; memory is raster-ordered at 64 words per image line.
- The block is the read-side counterpart of the 2D-DCT writer that fills that SRAM. It feeds a downstream quantiser/entropy stage or a self-checking monitor.

---
 rtl/dct_pkg.sv | 22 ++
 rtl/dct_block_reader_if.sv | 24 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/dct_block_reader.sv | 109 ++++++++++
 tb/tb_dct_block_reader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared geometry, SRAM widths, FSM codes and read tag for the DCT result SRAM
package dct_pkg;
  localparam int ADDR_W        = 15;
  localparam int DATA_W        = 64;
  localparam int BLK_COLS      = 64;
  localparam int BLK_ROWS      = 64;
  localparam int PIX_PER_WORD  = 8;
  localparam int LINES_PER_BLK = 8;
  localparam int RD_LAT        = 1;
  localparam int FIFO_DEPTH    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic valid;
    logic blk_last;
    logic img_last;
  } tag_t;
endpackage

// File: rtl/dct_block_reader_if.sv
// rtl/dct_block_reader_if.sv - SRAM read port and output stream bundle
interface dct_block_reader_if #(
  parameter int ADDR_W = dct_pkg::ADDR_W,
  parameter int DATA_W = dct_pkg::DATA_W
);
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_blk_last;
  logic              out_img_last;

  modport master (
    output mem_cs, mem_we, mem_addr, out_valid, out_data, out_blk_last, out_img_last,
    input  mem_rdata, out_ready
  );
  modport slave (
    input  mem_cs, mem_we, mem_addr, out_valid, out_data, out_blk_last, out_img_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO may still accept a word in the same cycle its head leaves.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (!do_push && do_pop) count <= count - CNTW'(1);
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/dct_block_reader.sv
// rtl/dct_block_reader.sv - streams a finished image from result SRAM in 8x8 block line order
module dct_block_reader #(
  parameter int ADDR_W     = dct_pkg::ADDR_W,
  parameter int DATA_W     = dct_pkg::DATA_W,
  parameter int BLK_COLS   = dct_pkg::BLK_COLS,
  parameter int BLK_ROWS   = dct_pkg::BLK_ROWS,
  parameter int RD_LAT     = dct_pkg::RD_LAT,
  parameter int FIFO_DEPTH = dct_pkg::FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  dct_block_reader_if.master bus
);
  import dct_pkg::*;

  localparam int CBW = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int RBW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int FW  = DATA_W + 2;

  logic [1:0]     state;
  logic [2:0]     line;
  logic [CBW-1:0] bcol;
  logic [RBW-1:0] brow;
  tag_t           tags [RD_LAT];
  logic [CW-1:0]  inflight;
  logic [FCW-1:0] fifo_count;
  logic [FW-1:0]  fifo_out;
  logic           fifo_empty, issue, last_line, last_addr, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tags[i].valid);
  end

  // Credit counts words already issued, so the FIFO can never overflow.
  assign issue     = (state == ST_READ) && ((CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH));
  assign last_line = (line == 3'(LINES_PER_BLK - 1));
  assign last_addr = last_line && (bcol == CBW'(BLK_COLS - 1)) && (brow == RBW'(BLK_ROWS - 1));

  assign bus.mem_cs   = issue;
  assign bus.mem_we   = 1'b0;
  assign bus.mem_addr = ADDR_W'((32'(brow) * 32'(LINES_PER_BLK) + 32'(line)) * 32'(BLK_COLS) + 32'(bcol));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      line  <= '0;
      bcol  <= '0;
      brow  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tags[i] <= '0;
    end else begin
      done    <= 1'b0;
      tags[0] <= '{valid: issue, blk_last: last_line, img_last: last_addr};
      for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
      if (issue) begin
        if (last_line) begin
          line <= '0;
          if (bcol == CBW'(BLK_COLS - 1)) begin
            bcol <= '0;
            brow <= (brow == RBW'(BLK_ROWS - 1)) ? '0 : brow + RBW'(1);
          end else begin
            bcol <= bcol + CBW'(1);
          end
        end else begin
          line <= line + 3'd1;
        end
      end
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_READ;
          busy  <= 1'b1;
        end
        ST_READ:  if (issue && last_addr) state <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty && (inflight == '0)) state <= ST_DONE;
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop = bus.out_valid && bus.out_ready;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tags[RD_LAT-1].valid),
    .push_data ({tags[RD_LAT-1].blk_last, tags[RD_LAT-1].img_last, bus.mem_rdata}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_out[DATA_W-1:0];
  assign bus.out_blk_last = !fifo_empty && fifo_out[DATA_W+1];
  assign bus.out_img_last = !fifo_empty && fifo_out[DATA_W];
endmodule

// File: tb/tb_dct_block_reader.sv
// tb/tb_dct_block_reader.sv - scoreboard bench for dct_block_reader at default and 2x2 geometry
module tb_dct_block_reader;
  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        i;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  int total = 0, bad = 0, cyc = 0;
  int words_a = 0, issued_a = 0, done_cnt_a = 0, img_cyc_a = 0;
  int words_b = 0, done_cnt_b = 0, img_cyc_b = 0;
  logic [63:0] cap_a [9];
  logic [63:0] last_a;
  exp_t q_a[$], q_b[$];

  int f9_tab [9] = '{0, 64, 128, 192, 256, 320, 384, 448, 1};
  int b_tab [32] = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15,
                     16, 18, 20, 22, 24, 26, 28, 30, 17, 19, 21, 23, 25, 27, 29, 31};

  dct_block_reader_if #(.ADDR_W(15), .DATA_W(64)) bus_a ();
  dct_block_reader_if #(.ADDR_W(15), .DATA_W(64)) bus_b ();

  dct_block_reader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );
  dct_block_reader #(.BLK_COLS(2), .BLK_ROWS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models preloaded with word[i] = i
  always @(posedge clk) if (bus_a.mem_cs) bus_a.mem_rdata <= 64'(bus_a.mem_addr);
  always @(posedge clk) if (bus_b.mem_cs) bus_b.mem_rdata <= 64'(bus_b.mem_addr);

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus_a.mem_cs) issued_a++;
      if (done_a) begin
        done_cnt_a++;
        check("a_busy_with_done", 66'(busy_a), 66'(0));
        check("a_done_latency", 66'((cyc - img_cyc_a >= 1) && (cyc - img_cyc_a <= 3)), 66'(1));
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (words_a < 9) cap_a[words_a] = bus_a.out_data;
        if (bus_a.out_img_last) begin
          img_cyc_a = cyc;
          last_a = bus_a.out_data;
        end
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_extra_word actual=%0h required=none", bus_a.out_data);
        end else begin
          e = q_a.pop_front();
          check("a_word", {bus_a.out_data, bus_a.out_blk_last, bus_a.out_img_last}, e);
        end
        words_a++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done_b) begin
        done_cnt_b++;
        check("b_done_latency", 66'((cyc - img_cyc_b >= 1) && (cyc - img_cyc_b <= 3)), 66'(1));
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (bus_b.out_img_last) img_cyc_b = cyc;
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_extra_word actual=%0h required=none", bus_b.out_data);
        end else begin
          e = q_b.pop_front();
          check("b_word", {bus_b.out_data, bus_b.out_blk_last, bus_b.out_img_last}, e);
        end
        words_b++;
      end
    end
  end

  task automatic fill_a(input int n);
    q_a.delete();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        for (int l = 0; l < 8; l++)
          if (q_a.size() < n)
            q_a.push_back('{d: 64'((r * 8 + l) * 64 + c), b: (l == 7),
                            i: (l == 7 && c == 63 && r == 63)});
  endtask

  task automatic wait_words_a(input int n);
    int k = 0;
    while (words_a < n && k < 20000) begin
      tick();
      k++;
    end
    check("a_reach_word", 66'(words_a >= n), 66'(1));
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    int k;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 66'(busy_a), 66'(0));
    check("rst_done", 66'(done_a), 66'(0));
    check("rst_mem_cs", 66'(bus_a.mem_cs), 66'(0));
    check("rst_mem_we", 66'(bus_a.mem_we), 66'(0));
    check("rst_mem_addr", 66'(bus_a.mem_addr), 66'(0));
    check("rst_out_valid", 66'(bus_a.out_valid), 66'(0));
    check("rst_blk_last", 66'(bus_a.out_blk_last), 66'(0));
    check("rst_img_last", 66'(bus_a.out_img_last), 66'(0));
    reset = 1'b0;
    tick();

    // full default image: ignored start at word 50, stall at word 203
    fill_a(32768);
    bus_a.out_ready = 1'b1;
    pulse_start_a();
    check("a_busy_after_start", 66'(busy_a), 66'(1));
    k = 1;
    while (!bus_a.out_valid && k < 10) begin
      tick();
      k++;
    end
    check("a_first_valid_latency", 66'(k), 66'(3));
    wait_words_a(50);
    pulse_start_a();
    check("a_busy_ignores_start", 66'(busy_a), 66'(1));
    wait_words_a(203);
    bus_a.out_ready = 1'b0;
    tick();
    held = bus_a.out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("a_stall_stable", 66'(bus_a.out_data), 66'(held));
    end
    check("a_stall_mem_cs", 66'(bus_a.mem_cs), 66'(0));
    check("a_stall_credit", 66'(issued_a - words_a), 66'(4));
    bus_a.out_ready = 1'b1;
    k = 0;
    while (done_cnt_a == 0 && k < 40000) begin
      tick();
      k++;
    end
    repeat (5) tick();
    check("a_done_once", 66'(done_cnt_a), 66'(1));
    check("a_word_count", 66'(words_a), 66'(32768));
    check("a_queue_empty", 66'(q_a.size()), 66'(0));
    check("a_last_word", 66'(last_a), 66'(32767));
    check("a_busy_after_done", 66'(busy_a), 66'(0));
    for (int i = 0; i < 9; i++) check("a_first9", 66'(cap_a[i]), 66'(f9_tab[i]));

    // reset at word 1000 aborts without done
    words_a = 0; issued_a = 0; done_cnt_a = 0;
    fill_a(2000);
    pulse_start_a();
    wait_words_a(1000);
    check("a_pre_reset_valid", 66'(bus_a.out_valid), 66'(1));
    reset = 1'b1;
    tick();
    check("a_reset_busy", 66'(busy_a), 66'(0));
    check("a_reset_valid", 66'(bus_a.out_valid), 66'(0));
    check("a_reset_mem_cs", 66'(bus_a.mem_cs), 66'(0));
    reset = 1'b0;
    q_a.delete();
    repeat (10) tick();
    check("a_no_stale_word", 66'(bus_a.out_valid), 66'(0));
    check("a_no_done_on_abort", 66'(done_cnt_a), 66'(0));

    // restart from address 0 with random ready
    words_a = 0; issued_a = 0;
    fill_a(4000);
    pulse_start_a();
    k = 0;
    while (words_a < 4000 && k < 20000) begin
      bus_a.out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    bus_a.out_ready = 1'b0;
    repeat (3) tick();
    check("a_rand_count", 66'(words_a), 66'(4000));
    check("a_rand_queue_empty", 66'(q_a.size()), 66'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_a.delete();
    tick();

    // 2x2 geometry, ready high then random
    for (int run = 0; run < 2; run++) begin
      q_b.delete();
      for (int i = 0; i < 32; i++)
        q_b.push_back('{d: 64'(b_tab[i]), b: (i % 8 == 7), i: (i == 31)});
      words_b = 0;
      done_cnt_b = 0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      k = 0;
      while (done_cnt_b == 0 && k < 1000) begin
        bus_b.out_ready = (run == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      repeat (4) tick();
      check("b_done_once", 66'(done_cnt_b), 66'(1));
      check("b_word_count", 66'(words_b), 66'(32));
      check("b_queue_empty", 66'(q_b.size()), 66'(0));
      check("b_idle_after", 66'(busy_b), 66'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
